// File: rtl/fixed_divider_pkg.sv
// Shared fixed-point definitions for the sequential SQm.n divider:
// word/quotient widths, the saturation constant, FSM state encoding
// and a magnitude helper.
package fixed_divider_pkg;

   localparam int FD_M = 12;                // integer bits, including sign
   localparam int FD_N = 12;                // fractional bits
   localparam int FD_W = FD_M + FD_N;       // word width
   localparam int FD_Q = FD_M + 2 * FD_N;   // quotient width

   // One SQm.n word.
   typedef logic [FD_W-1:0] qmn_t;

   // Largest positive SQm.n value (0x7FF..F).
   localparam qmn_t FD_NSAT = {1'b0, {(FD_W-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FINISH = 2'd2
   } fd_state_e;

   // Magnitude of a two's complement word as an unsigned word.
   // The most negative value maps to 2^(W-1), which still fits unsigned.
   function automatic qmn_t fd_abs(input qmn_t v);
      return v[FD_W-1] ? -v : v;
   endfunction

endpackage

// File: rtl/fixed_divider_if.sv
// Request/result bundle of the fixed-point divider.
// master: the requester; slave: the divider.
interface fixed_divider_if #(
   parameter int W = 24
);
   logic         i_start;
   logic [W-1:0] i_num;
   logic [W-1:0] i_den;
   logic         i_abs;
   logic         o_busy;
   logic         o_valid;
   logic [W-1:0] o_data;
   logic         o_sat;
   logic         o_div0;

   modport master (
      output i_start, i_num, i_den, i_abs,
      input  o_busy, o_valid, o_data, o_sat, o_div0
   );

   modport slave (
      input  i_start, i_num, i_den, i_abs,
      output o_busy, o_valid, o_data, o_sat, o_div0
   );
endinterface

// File: rtl/fixed_divider_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder and try to subtract the divisor. Purely combinational.
// Relies on rem_in < den, which keeps every remainder within W bits.
module fixed_divider_step #(
   parameter int W = 24
) (
   input  logic [W-1:0] rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] den,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);
   logic [W:0] shifted;
   logic [W:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, den};
   // No borrow out of the trial subtract means the divisor fitted.
   assign q_bit   = ~diff[W];
   assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/fixed_divider.sv
// Sequential signed SQm.n divider: o_data = i_num / i_den, truncated
// toward zero, by restoring long division on magnitudes.
// Optional build macro FIXED_DIVIDER_RADIX4_EN: two chained step units
// retire two quotient bits per clock (quotient width must be even).
// Without it one bit is retired per clock.
module fixed_divider
   import fixed_divider_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   fixed_divider_if.slave   bus
);
   localparam int W  = FD_W;
   localparam int N  = FD_N;
   localparam int Q  = FD_Q;
   localparam int CW = $clog2(Q + 1);
`ifdef FIXED_DIVIDER_RADIX4_EN
   localparam int SPC = 2;      // quotient bits per clock
`else
   localparam int SPC = 1;
`endif

   fd_state_e       state_reg, state_next;
   logic            sign_reg;
   logic            div0_reg;
   logic [W-1:0]    den_reg;
   logic [Q-1:0]    dvd_reg;
   logic [Q-1:0]    quot_reg;
   logic [W-1:0]    rem_reg;
   logic [CW-1:0]   cnt_reg;
   logic            valid_reg;
   logic [W-1:0]    data_reg;
   logic            sat_reg;
   logic            div0_out_reg;

   logic            accept;
   logic            den_zero;
   logic            last_step;
   logic [W-1:0]    rem_chain [0:SPC];
   logic [SPC-1:0]  q_bits;
   logic            sat_calc;
   logic [W-1:0]    mag_calc;
   logic [W-1:0]    result_calc;

   assign accept    = (state_reg == IDLE) && bus.i_start;
   assign den_zero  = (bus.i_den == '0);
   assign last_step = (cnt_reg == CW'(SPC));

   // Chain of step units; unit gi consumes dividend bit Q-1-gi and
   // produces the quotient bit of the same weight within this clock.
   assign rem_chain[0] = rem_reg;
   generate
      for (genvar gi = 0; gi < SPC; gi++) begin : g_step
         fixed_divider_step #(.W(W)) u_step (
            .rem_in  (rem_chain[gi]),
            .bit_in  (dvd_reg[Q-1-gi]),
            .den     (den_reg),
            .rem_out (rem_chain[gi+1]),
            .q_bit   (q_bits[SPC-1-gi])
         );
      end
   endgenerate

   // Result stage: saturate on overflow or divide-by-zero, then restore sign.
   assign sat_calc    = div0_reg | (|quot_reg[Q-1:W-1]);
   assign mag_calc    = sat_calc ? FD_NSAT : quot_reg[W-1:0];
   assign result_calc = sign_reg ? -mag_calc : mag_calc;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic; a zero divisor skips straight to the result.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.i_start) state_next = den_zero ? FINISH : DIVIDE;
         DIVIDE:  if (last_step)   state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on accept, then one shift/subtract round per clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_reg <= 1'b0;
         div0_reg <= 1'b0;
         den_reg  <= '0;
         dvd_reg  <= '0;
         quot_reg <= '0;
         rem_reg  <= '0;
         cnt_reg  <= '0;
      end else if (accept) begin
         // Divide-by-zero takes the numerator's sign alone.
         sign_reg <= (den_zero ? bus.i_num[W-1] : (bus.i_num[W-1] ^ bus.i_den[W-1]))
                     & ~bus.i_abs;
         div0_reg <= den_zero;
         den_reg  <= fd_abs(bus.i_den);
         dvd_reg  <= Q'(fd_abs(bus.i_num)) << N;
         quot_reg <= '0;
         rem_reg  <= '0;
         cnt_reg  <= CW'(Q);
      end else if (state_reg == DIVIDE) begin
         rem_reg  <= rem_chain[SPC];
         dvd_reg  <= dvd_reg << SPC;
         quot_reg <= {quot_reg[Q-SPC-1:0], q_bits};
         cnt_reg  <= cnt_reg - CW'(SPC);
      end
   end

   // Output registers: one-cycle valid pulse, result held until the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg    <= 1'b0;
         data_reg     <= '0;
         sat_reg      <= 1'b0;
         div0_out_reg <= 1'b0;
      end else begin
         valid_reg <= (state_reg == FINISH);
         if (state_reg == FINISH) begin
            data_reg     <= result_calc;
            sat_reg      <= sat_calc;
            div0_out_reg <= div0_reg;
         end
      end
   end

   assign bus.o_busy  = (state_reg != IDLE);
   assign bus.o_valid = valid_reg;
   assign bus.o_data  = data_reg;
   assign bus.o_sat   = sat_reg;
   assign bus.o_div0  = div0_out_reg;
endmodule
